// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: one result bit per clock, LSB first,
// carrying a registered borrow between bits; result and final borrow held until the next run completes.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic [WIDTH-1:0]   res_reg, res_next;
    logic               br_reg, br_next;
    logic [IW-1:0]      idx_reg, idx_next;
    logic [WIDTH-1:0]   diff_reg, diff_next;
    logic               borrow_reg, borrow_next;

    logic               bit_a, bit_b, bit_d, bit_br;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            res_reg    <= '0;
            br_reg     <= 1'b0;
            idx_reg    <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            res_reg    <= res_next;
            br_reg     <= br_next;
            idx_reg    <= idx_next;
            diff_reg   <= diff_next;
            borrow_reg <= borrow_next;
        end
    end

    // Full-subtractor cell for the bit currently selected by the index.
    assign bit_a  = a_reg[idx_reg];
    assign bit_b  = b_reg[idx_reg];
    assign bit_d  = bit_a ^ bit_b ^ br_reg;
    assign bit_br = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_reg);

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        res_next    = res_reg;
        br_next     = br_reg;
        idx_next    = idx_reg;
        diff_next   = diff_reg;
        borrow_next = borrow_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    a_next     = a;
                    b_next     = b;
                    res_next   = '0;
                    br_next    = 1'b0;
                    idx_next   = '0;
                end
            end
            RUN: begin
                res_next[idx_reg] = bit_d;
                br_next           = bit_br;
                // The last bit goes straight into diff so no extra cycle is needed.
                if (idx_reg == LAST_IDX) begin
                    state_next  = DONE;
                    diff_next   = res_next;
                    borrow_next = bit_br;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == DONE);
    assign diff       = diff_reg;
    assign borrow_out = borrow_reg;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl at WIDTH 8, 4 and 1; expected results
// are queued at issue time and compared when each instance pulses done.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0, busy8, done8, borrow8;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic       start4 = 1'b0, busy4, done4, borrow4;
    logic [3:0] a4 = '0, b4 = '0, diff4;
    logic       start1 = 1'b0, busy1, done1, borrow1;
    logic [0:0] a1 = '0, b1 = '0, diff1;

    int tests = 0;
    int fails = 0;

    logic [8:0] q8[$];
    logic [4:0] q4[$];
    logic [1:0] q1[$];
    logic [8:0] e8;
    logic [4:0] e4;
    logic [1:0] e1;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8)
    );
    serial_sub_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow4)
    );
    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(borrow1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboards: pop one expectation per done pulse.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) chk("done8_unexpected", {31'd0, done8}, 32'd0);
            else begin
                e8 = q8.pop_front();
                chk("diff8", {24'd0, diff8}, {24'd0, e8[7:0]});
                chk("borrow8", {31'd0, borrow8}, {31'd0, e8[8]});
                $display("[TB] w8 result diff=%02h borrow=%0b", diff8, borrow8);
            end
        end
        if (done4 === 1'b1) begin
            if (q4.size() == 0) chk("done4_unexpected", {31'd0, done4}, 32'd0);
            else begin
                e4 = q4.pop_front();
                chk("diff4", {28'd0, diff4}, {28'd0, e4[3:0]});
                chk("borrow4", {31'd0, borrow4}, {31'd0, e4[4]});
            end
        end
        if (done1 === 1'b1) begin
            if (q1.size() == 0) chk("done1_unexpected", {31'd0, done1}, 32'd0);
            else begin
                e1 = q1.pop_front();
                chk("res1", {30'd0, borrow1, diff1}, {30'd0, e1});
                $display("[TB] w1 result borrow=%0b diff=%0b", borrow1, diff1);
            end
        end
    end

    task automatic go8(input logic [7:0] av, input logic [7:0] bv, input bit scramble);
        int n;
        q8.push_back({av < bv, 8'(av - bv)});
        @(posedge clk); #1;
        a8 = av; b8 = bv; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("busy8_accept", {31'd0, busy8}, 32'd1);
        if (scramble) begin
            a8 = ~av;
            b8 = av;
        end
        n = 0;
        while (done8 !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done8_seen", {31'd0, done8}, 32'd1);
        chk("latency8", n, 32'd8);
        @(posedge clk); #1;
        chk("done8_pulse", {31'd0, done8}, 32'd0);
        chk("busy8_idle", {31'd0, busy8}, 32'd0);
    endtask

    task automatic go4(input logic [3:0] av, input logic [3:0] bv);
        int n;
        q4.push_back({av < bv, 4'(av - bv)});
        @(posedge clk); #1;
        a4 = av; b4 = bv; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        n = 0;
        while (done4 !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency4", n, 32'd4);
        @(posedge clk); #1;
        chk("done4_pulse", {31'd0, done4}, 32'd0);
    endtask

    task automatic go1(input logic av, input logic bv, input logic [1:0] exp);
        int n;
        q1.push_back(exp);
        @(posedge clk); #1;
        a1 = av; b1 = bv; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("busy1_accept", {31'd0, busy1}, 32'd1);
        n = 0;
        while (done1 !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency1", n, 32'd1);
        @(posedge clk); #1;
        chk("done1_pulse", {31'd0, done1}, 32'd0);
    endtask

    initial begin
        int n;
        longint t, tp;
        logic [1:0] exp1 [4];

        // Reset state, sampled away from any edge.
        #2;
        chk("rst_busy8", {31'd0, busy8}, 32'd0);
        chk("rst_done8", {31'd0, done8}, 32'd0);
        chk("rst_diff8", {24'd0, diff8}, 32'd0);
        chk("rst_borrow8", {31'd0, borrow8}, 32'd0);
        #10;
        rst_n = 1'b1;

        go8(8'h5A, 8'h3C, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("diff8_hold", {24'd0, diff8}, 32'h1E);
        go8(8'h00, 8'h01, 1'b0);
        go8(8'h80, 8'h80, 1'b1);
        go8(8'hFF, 8'h00, 1'b1);
        go8(8'h00, 8'h01, 1'b0);

        // Abort at bit index 4: outputs clear immediately, no done follows.
        @(posedge clk); #1;
        a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_diff8", {24'd0, diff8}, 32'd0);
        chk("abort_borrow8", {31'd0, borrow8}, 32'd0);
        chk("abort_busy8", {31'd0, busy8}, 32'd0);
        chk("abort_done8", {31'd0, done8}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_nodone8", {31'd0, done8}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("post_abort_nodone8", {31'd0, done8}, 32'd0);
        end
        go8(8'h03, 8'h05, 1'b0);

        // Start held high: back-to-back runs every WIDTH+2 cycles.
        repeat (3) q8.push_back({1'b0, 8'h0F});
        @(posedge clk); #1;
        a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;
        a8 = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        a8 = 8'h10;
        tp = 0;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (done8 !== 1'b1 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("cont_done8", {31'd0, done8}, 32'd1);
            t = $time;
            if (i > 0) chk("cont_interval", 32'(t - tp), 32'd100);
            tp = t;
            @(posedge clk); #1;
            if (i == 2) start8 = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("cont_stopped", {31'd0, busy8}, 32'd0);

        // WIDTH=4 exhaustive sweep.
        for (int ai = 0; ai < 16; ai++)
            for (int bi = 0; bi < 16; bi++)
                go4(4'(ai), 4'(bi));
        $display("[TB] w4 sweep issued 256 pairs");

        // WIDTH=1 sweep; table indexed by {a,b}.
        exp1[0] = 2'b00;
        exp1[1] = 2'b11;
        exp1[2] = 2'b01;
        exp1[3] = 2'b00;
        for (int k = 0; k < 4; k++)
            go1(k[1], k[0], exp1[k]);

        repeat (3) @(posedge clk);
        #1;
        chk("q8_drained", q8.size(), 32'd0);
        chk("q4_drained", q4.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result bit width; legal range is 1 to 32.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low; internal synchronisation of release is not required.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; captured on the accepting edge.
REQ-006 b  input  WIDTH  subtrahend; captured on the accepting edge.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 done  output  1  single-cycle pulse; result valid.
REQ-009 diff  output  WIDTH  a minus b, modulo 2^WIDTH.
REQ-010 borrow_out  output  1  final borrow; 1 when a is less than b (unsigned).

Function
REQ-011 The block SHALL be a bit-serial subtractor sequencer that computes one bit per clock, LSB first, using a registered borrow.
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE to RUN SHALL occur on an edge with start=1; on that edge the block latches a and b, clears the internal borrow to 0, and clears the bit index to 0.
REQ-014 When start=0, the block SHALL remain in IDLE.
REQ-015 Each RUN edge at bit index i SHALL compute d_i = a_i ^ b_i ^ br and br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-016 On each RUN edge, d_i SHALL be written to bit i of an internal result register, and the index SHALL increment.
REQ-017 RUN SHALL last exactly WIDTH edges; on the edge that processes bit WIDTH-1, the FSM SHALL transition to DONE.
REQ-018 On that same edge, diff SHALL load the internal result register (including bit WIDTH-1) and borrow_out SHALL load br_next.
REQ-019 done SHALL be 1 only while in DONE, for exactly one cycle; DONE SHALL return to IDLE unconditionally on the next edge.
REQ-020 Latency: if start is accepted on edge k, done SHALL be high in the cycle after edge k+WIDTH, and busy SHALL be high from edge k to edge k+WIDTH+1.
REQ-021 diff and borrow_out SHALL update only on entry to DONE, and SHALL hold their values until the next entry to DONE or reset.
REQ-022 start SHALL be ignored in RUN and DONE (no queuing); changes to a or b after acceptance SHALL have no effect.
REQ-023 A start asserted in the first IDLE cycle after DONE SHALL be accepted; the minimum issue interval is WIDTH+2 cycles.
REQ-024 The bit index SHALL be wide enough to count to WIDTH-1 and SHALL not wrap during RUN.
REQ-025 When WIDTH=1, RUN SHALL last one edge.

Reset
REQ-026 rst_n=0 SHALL immediately force the following, regardless of clk: state IDLE, busy=0, done=0, diff=0, borrow_out=0, index=0, internal borrow=0, latched operands=0.
REQ-027 A reset asserted during RUN or DONE SHALL abort the operation; no done pulse SHALL follow, and no partial result SHALL appear on diff.
REQ-028 After rst_n rises, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-029 WIDTH=8, a=0x5A, b=0x3C, start pulsed 1 cycle -> done high exactly 8 edges after acceptance; diff=0x1E, borrow_out=0.
REQ-030 a=0x00, b=0x01 -> diff=0xFF, borrow_out=1; a=0x80, b=0x80 -> diff=0x00, borrow_out=0.
REQ-031 start held high continuously with a=0x10, b=0x01 -> results 0x0F/0 every 10 cycles (WIDTH+2); changing a mid-RUN does not alter the result.
REQ-032 rst_n pulsed low at bit index 4 of a run -> outputs 0 immediately, no done pulse; a following run with a=0x03, b=0x05 -> diff=0xFE, borrow_out=1.
REQ-033 Exhaustive sweep, WIDTH=4, all 256 (a,b) pairs -> diff=(a-b) mod 16 and borrow_out=(a<b) for every pair.
REQ-034 WIDTH=1 sweep over the four (a,b) pairs -> {borrow_out,diff} = 00, 11, 01, 00 for (a,b) = 00, 01, 10, 11; done one edge after acceptance.
